hazard_sched: RTL and testbench

- Pipeline hazard scheduler that sequences the ID/EX pipeline register and its neighbours.
- Each cycle it decides whether PC, IF/ID and ID/EX advance, hold or take a bubble, and whether EX/MEM captures a bubble.
- It covers three cases:
  - load-use hazards between the EX and ID instructions (integer and float register files);
  - taken-branch squash;
  - multi-cycle float ops that must occupy EX for MC_LAT cycles.
- Sits beside the pipeline registers. Its stall/flush outputs drive their stall and iFlush inputs directly.

---
 rtl/hazard_sched.sv | 113 +++++++++++
 tb/tb_hazard_sched.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_sched.sv
// Hazard scheduler for the ID/EX pipeline register: load-use stalls, branch squash, multi-cycle EX hold.
// Optional HAZARD_STATS_EN adds saturating stall/flush event counters.
module hazard_sched #(
   parameter int unsigned MC_LAT = 4,
   parameter int unsigned CNT_W  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       id_float,
   input  logic       ex_bubble,
   input  logic       ex_load,
   input  logic [4:0] ex_dst,
   input  logic       ex_float,
   input  logic       ex_mc,
   input  logic       branch_taken,
   output logic       stall_pc,
   output logic       stall_ifid,
   output logic       stall_idex,
   output logic       flush_ifid,
   output logic       flush_idex,
   output logic       bubble_exmem
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   typedef enum logic {S_RUN, S_MC} state_t;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             w_ex_valid, w_src_match, w_load_use;

   assign w_ex_valid  = ~ex_bubble;
   assign w_src_match = (ex_dst == id_rs) | (id_uses_rt & (ex_dst == id_rt));
   // Integer r0 is hardwired zero and never a true dependency; float f0 is a real register.
   assign w_load_use  = w_ex_valid & ex_load & (ex_float == id_float)
                      & (ex_float | (ex_dst != '0)) & w_src_match;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      stall_pc     = 1'b0;
      stall_ifid   = 1'b0;
      stall_idex   = 1'b0;
      flush_ifid   = 1'b0;
      flush_idex   = 1'b0;
      bubble_exmem = 1'b0;
      // Outputs are combinational, so reset must mask them directly rather than rely on state.
      if (!rst) begin
         case (r_state)
            S_RUN: begin
               if (w_ex_valid & ex_mc) begin
                  stall_pc     = 1'b1;
                  stall_ifid   = 1'b1;
                  stall_idex   = 1'b1;
                  bubble_exmem = 1'b1;
                  w_cnt_nxt    = CNT_W'(MC_LAT - 2);
                  w_state_nxt  = S_MC;
               end else if (w_ex_valid & branch_taken) begin
                  flush_ifid = 1'b1;
                  flush_idex = 1'b1;
               end else if (w_load_use) begin
                  stall_pc   = 1'b1;
                  stall_ifid = 1'b1;
                  flush_idex = 1'b1;
               end
            end
            S_MC: begin
               if (r_cnt != '0) begin
                  stall_pc     = 1'b1;
                  stall_ifid   = 1'b1;
                  stall_idex   = 1'b1;
                  bubble_exmem = 1'b1;
                  w_cnt_nxt    = r_cnt - CNT_W'(1);
               end else begin
                  w_state_nxt = S_RUN;
               end
            end
            default: w_state_nxt = S_RUN;
         endcase
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_pc && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
         if (flush_ifid && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: constant vector table, hand-written MC/reset sequences,
// and randomized stimulus against an occupancy-based reference model.
module tb_hazard_sched;
   localparam int unsigned MC_LAT = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_dst;
   logic       id_uses_rt, id_float, ex_bubble, ex_load, ex_float, ex_mc, branch_taken;
   logic       stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex, bubble_exmem;
`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   hazard_sched #(.MC_LAT(MC_LAT), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_float(id_float),
      .ex_bubble(ex_bubble), .ex_load(ex_load), .ex_dst(ex_dst), .ex_float(ex_float),
      .ex_mc(ex_mc), .branch_taken(branch_taken),
      .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
      .flush_ifid(flush_ifid), .flush_idex(flush_idex), .bubble_exmem(bubble_exmem)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int mc_age = 0;   // cycles the current multi-cycle op has already spent in EX (0 = none)

   // Output bundle order: {stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex, bubble_exmem}
   localparam logic [5:0] O_IDLE = 6'b000000;
   localparam logic [5:0] O_LU   = 6'b110010;
   localparam logic [5:0] O_BR   = 6'b000110;
   localparam logic [5:0] O_MC   = 6'b111001;

   typedef struct {
      logic [4:0] rs, rt;
      logic       uses_rt, idf, bub, load;
      logic [4:0] dst;
      logic       exf, mc, br;
      logic [5:0] exp;
   } vec_t;

   vec_t tbl[11];

   function automatic logic [5:0] outs();
      return {stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex, bubble_exmem};
   endfunction

   task automatic check6(input string nm, input logic [5:0] got, input logic [5:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %b expected %b at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses, input logic idf,
                        input logic bub, input logic load, input logic [4:0] dst, input logic exf,
                        input logic mc, input logic br);
      id_rs = rs; id_rt = rt; id_uses_rt = uses; id_float = idf;
      ex_bubble = bub; ex_load = load; ex_dst = dst; ex_float = exf;
      ex_mc = mc; branch_taken = br;
   endtask

   // Reference: an MC op holds EX for MC_LAT cycles, stalling all but the last one.
   task automatic model_cycle(output logic [5:0] e);
      logic same_file, reg_real, reads_dst;
      if (mc_age > 0) begin
         if (mc_age + 1 < int'(MC_LAT)) begin
            e = O_MC;
            mc_age++;
         end else begin
            e = O_IDLE;
            mc_age = 0;
         end
      end else if (ex_bubble) begin
         e = O_IDLE;
      end else if (ex_mc) begin
         e = O_MC;
         mc_age = 1;
      end else if (branch_taken) begin
         e = O_BR;
      end else begin
         same_file = (ex_float && id_float) || (!ex_float && !id_float);
         reg_real  = ex_float || (ex_dst != 5'd0);
         reads_dst = (id_rs == ex_dst) || (id_uses_rt && id_rt == ex_dst);
         e = (ex_load && same_file && reg_real && reads_dst) ? O_LU : O_IDLE;
      end
   endtask

   initial begin
      logic [5:0] e;

      //                 rs  rt  use idf bub ld  dst exf mc  br   expected
      tbl[0]  = '{5'd5, 5'd0, 0, 0, 0, 1, 5'd5, 0, 0, 0, O_LU};   // load-use on rs
      tbl[1]  = '{5'd5, 5'd0, 0, 0, 1, 1, 5'd5, 0, 0, 0, O_IDLE}; // EX is a bubble
      tbl[2]  = '{5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0, 0, O_IDLE}; // integer r0
      tbl[3]  = '{5'd3, 5'd0, 0, 0, 0, 1, 5'd3, 1, 0, 0, O_IDLE}; // file mismatch
      tbl[4]  = '{5'd7, 5'd0, 1, 1, 0, 1, 5'd0, 1, 0, 0, O_LU};   // float f0 via rt
      tbl[5]  = '{5'd5, 5'd0, 0, 0, 0, 1, 5'd5, 0, 0, 1, O_BR};   // branch beats load-use
      tbl[6]  = '{5'd1, 5'd9, 0, 0, 0, 1, 5'd9, 0, 0, 0, O_IDLE}; // rt not read
      tbl[7]  = '{5'd1, 5'd9, 1, 0, 0, 1, 5'd9, 0, 0, 0, O_LU};   // rt read
      tbl[8]  = '{5'd4, 5'd0, 0, 0, 0, 0, 5'd4, 0, 0, 0, O_IDLE}; // not a load
      tbl[9]  = '{5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 1, O_IDLE}; // branch in bubble slot
      tbl[10] = '{5'd2, 5'd3, 1, 0, 0, 0, 5'd8, 0, 0, 1, O_BR};   // plain branch

      rst = 1'b1;
      drive(5'd5, 5'd0, 0, 0, 0, 1, 5'd5, 0, 0, 0);
      #2 check6("reset_outputs", outs(), O_IDLE);
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i].rs, tbl[i].rt, tbl[i].uses_rt, tbl[i].idf, tbl[i].bub, tbl[i].load,
               tbl[i].dst, tbl[i].exf, tbl[i].mc, tbl[i].br);
         #2 check6($sformatf("vec%0d", i), outs(), tbl[i].exp);
      end

      // Multi-cycle op held in EX; a branch mid-hold must be ignored.
      for (int unsigned c = 0; c < 5; c++) begin
         @(negedge clk);
         drive(5'd5, 5'd0, 0, 0, 0, 1, 5'd5, 0, (c < 4) ? 1'b1 : 1'b0, (c == 2) ? 1'b1 : 1'b0);
         #2 check6($sformatf("mc_cycle%0d", c), outs(),
                   (c < MC_LAT - 1) ? O_MC : ((c == MC_LAT - 1) ? O_IDLE : O_LU));
      end

      // Asynchronous reset in the second stalled cycle.
      @(negedge clk);
      drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd1, 0, 1, 0);
      #2 check6("rmc_detect", outs(), O_MC);
      @(negedge clk);
      #2 check6("rmc_stall2", outs(), O_MC);
      #1 rst = 1'b1;
      #1 check6("rmc_async", outs(), O_IDLE);
      @(negedge clk);
      check6("rmc_held", outs(), O_IDLE);
      rst = 1'b0;
      drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd1, 0, 0, 0);
      #2 check6("rmc_release", outs(), O_IDLE);
      @(negedge clk);
      drive(5'd6, 5'd0, 0, 0, 0, 1, 5'd6, 0, 0, 0);
      #2 check6("rmc_run_lu", outs(), O_LU);

`ifdef HAZARD_STATS_EN
      @(negedge clk);
      rst = 1'b1;
      #2 rst = 1'b0;
      drive(5'd5, 5'd0, 0, 0, 0, 1, 5'd5, 0, 0, 0);
      @(negedge clk); drive(5'd5, 5'd0, 0, 0, 1, 1, 5'd5, 0, 0, 0);
      @(negedge clk); drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd1, 0, 0, 1);
      for (int unsigned c = 0; c < MC_LAT; c++) begin
         @(negedge clk); drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd1, 0, 1, 0);
      end
      @(negedge clk); drive(5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 0);
      checks++;
      if (stall_cnt !== 32'd4) begin
         errors++;
         $display("FAIL stall_cnt got %0d expected 4", stall_cnt);
      end
      checks++;
      if (flush_cnt !== 32'd1) begin
         errors++;
         $display("FAIL flush_cnt got %0d expected 1", flush_cnt);
      end
`endif

      // Randomized stimulus against the reference model (starts in RUN).
      mc_age = 0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
               1'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom),
               5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 5) == 0));
         #2 model_cycle(e);
         check6($sformatf("rand%0d", n), outs(), e);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
